// File: rtl/nf_reg_scan_pkg.sv
// ---------------------------------------------------------------------------
// nf_reg_scan_pkg
// Shared types and default constants for the register scan controller.
//   scan_state_t      : controller state (MANUAL / AUTO_RUN / AUTO_HOLD)
//   DWELL_DEFAULT     : cycles each address is shown in auto-run (0.5 s @ 50 MHz)
//   DB_CYCLES_DEFAULT : cycles a button level must be stable (10 ms @ 50 MHz)
// ---------------------------------------------------------------------------
package nf_reg_scan_pkg;

   typedef enum logic [1:0] {
      ST_MANUAL    = 2'd0,
      ST_AUTO_RUN  = 2'd1,
      ST_AUTO_HOLD = 2'd2
   } scan_state_t;

   localparam int DWELL_DEFAULT     = 25_000_000;
   localparam int DB_CYCLES_DEFAULT = 500_000;

endpackage : nf_reg_scan_pkg

// File: rtl/nf_reg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// nf_reg_scan_ctrl_if
// Register read port between the scan controller and the core register file.
//   reg_addr : register index driven by the controller
//   reg_data : read data, combinational from reg_addr (no handshake; the
//              register file answers in the same cycle)
// Modports: master = controller side, slave = register file side.
// ---------------------------------------------------------------------------
interface nf_reg_scan_ctrl_if;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;

   modport master (output reg_addr, input  reg_data);
   modport slave  (input  reg_addr, output reg_data);
endinterface : nf_reg_scan_ctrl_if

// File: rtl/nf_debounce.sv
// ---------------------------------------------------------------------------
// nf_debounce
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted falling edge (button pressed, active low).
//   clk, resetn : system clock, asynchronous active-low reset
//   btn_n       : raw asynchronous button, active low
//   press       : registered one-cycle pulse per accepted press
// A level is accepted only after DB_CYCLES consecutive cycles differing from
// the currently accepted level; release is filtered the same way, so one
// physical press yields exactly one pulse.
// ---------------------------------------------------------------------------
module nf_debounce #(
   parameter int DB_W      = 20,
   parameter int DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic btn_n,
   output logic press
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            sync1, sync2;
   logic            level_q;
   logic [DB_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            // DB_CYCLES-th consecutive differing cycle: accept new level.
            cnt_q   <= '0;
            level_q <= sync2;
            press   <= level_q & ~sync2;
         end else begin
            cnt_q <= cnt_q + DB_W'(1);
         end
      end
   end

endmodule : nf_debounce

// File: rtl/nf_reg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// nf_reg_scan_ctrl
// Debug-port sequencer feeding the core register read port from board
// switches/keys. Manual mode forwards the switch address; auto mode steps
// through all 32 registers, holding each for DWELL cycles; the debounced
// step button pauses/resumes the scan.
//   clk, resetn  : system clock, asynchronous active-low reset
//   mode_auto    : async switch, 1 = auto scan, 0 = manual
//   manual_addr  : async switches, register index for manual mode
//   step_n       : async push-button (active low), pause/resume in auto mode
//   rd           : register read port (reg_addr out, reg_data in)
//   disp_data    : registered reg_data
//   disp_addr    : address that produced disp_data (same pipeline stage)
//   scan_run     : 1 while in AUTO_RUN
//   state_dbg    : current controller state
// ---------------------------------------------------------------------------
module nf_reg_scan_ctrl
   import nf_reg_scan_pkg::*;
#(
   parameter int DWELL_W   = 26,
   parameter int DWELL     = DWELL_DEFAULT,
   parameter int DB_W      = 20,
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       mode_auto,
   input  logic [4:0]                 manual_addr,
   input  logic                       step_n,
   nf_reg_scan_ctrl_if.master         rd,
   output logic [31:0]                disp_data,
   output logic [4:0]                 disp_addr,
   output logic                       scan_run,
   output scan_state_t                state_dbg
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

   logic               mode_s1, mode_s2;
   logic [4:0]         man_s1, man_s2;
   logic               press;
   scan_state_t        state_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [4:0]         addr_q;

   assign rd.reg_addr = addr_q;
   assign state_dbg   = state_q;

   nf_debounce #(
      .DB_W      (DB_W),
      .DB_CYCLES (DB_CYCLES)
   ) u_step_db (
      .clk    (clk),
      .resetn (resetn),
      .btn_n  (step_n),
      .press  (press)
   );

   // Switch synchronizers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
         man_s1  <= '0;
         man_s2  <= '0;
      end else begin
         mode_s1 <= mode_auto;
         mode_s2 <= mode_s1;
         man_s1  <= manual_addr;
         man_s2  <= man_s1;
      end
   end

   // Controller FSM with dwell counter and address register.
   // Mode switch-off wins over press and dwell expiry; in AUTO_RUN a press
   // coinciding with expiry still lets the address advance before holding.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_MANUAL;
         dwell_q  <= '0;
         addr_q   <= '0;
         scan_run <= 1'b0;
      end else begin
         case (state_q)
            ST_MANUAL: begin
               if (mode_s2) begin
                  state_q  <= ST_AUTO_RUN;
                  dwell_q  <= '0;
                  scan_run <= 1'b1;
               end else begin
                  addr_q <= man_s2;
               end
            end
            ST_AUTO_RUN: begin
               if (!mode_s2) begin
                  state_q  <= ST_MANUAL;
                  scan_run <= 1'b0;
               end else begin
                  if (dwell_q == DWELL_LAST) begin
                     dwell_q <= '0;
                     addr_q  <= addr_q + 5'd1;
                  end else begin
                     dwell_q <= dwell_q + DWELL_W'(1);
                  end
                  if (press) begin
                     state_q  <= ST_AUTO_HOLD;
                     scan_run <= 1'b0;
                  end
               end
            end
            ST_AUTO_HOLD: begin
               // Address and dwell count stay frozen; resume continues the count.
               if (!mode_s2) begin
                  state_q <= ST_MANUAL;
               end else if (press) begin
                  state_q  <= ST_AUTO_RUN;
                  scan_run <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_MANUAL;
               scan_run <= 1'b0;
            end
         endcase
      end
   end

   // Display pipeline: data and its address captured together every cycle,
   // so register contents changing while holding remain visible.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disp_data <= '0;
         disp_addr <= '0;
      end else begin
         disp_data <= rd.reg_data;
         disp_addr <= addr_q;
      end
   end

endmodule : nf_reg_scan_ctrl

// File: doc/nf_reg_scan_ctrl.md
# nf_reg_scan_ctrl

Debug-port sequencer between the board switches/keys and the core's register read port (`reg_addr`/`reg_data`). In manual mode it forwards a switch-selected register address; in auto mode it steps through all 32 registers with a programmable dwell time, and a debounced push-button pauses or resumes the scan. Read data and its address are registered together for the seven-segment and LED drivers, so the displayed value always matches the displayed index.

## Interface
Parameters:
- `DWELL_W`, 26: width of the dwell counter.
- `DWELL`, 25_000_000: cycles each address is held in auto-run (0.5 s at 50 MHz); legal range 1 to 2^DWELL_W-1.
- `DB_W`, 20: width of the debounce counter.
- `DB_CYCLES`, 500_000: cycles a button level must be stable before it is accepted; legal minimum 1.

Ports:
- `clk` in 1: single system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `mode_auto` in 1: asynchronous switch; 1 selects auto scan, 0 selects manual.
- `manual_addr` in 5: asynchronous switches; register index used in manual mode.
- `step_n` in 1: asynchronous push-button, active low; pause/resume in auto mode.
- `reg_addr` out 5: address to the core's register read port.
- `reg_data` in 32: read data, combinational from `reg_addr`.
- `disp_data` out 32: registered `reg_data`, aligned with `disp_addr`.
- `disp_addr` out 5: address that produced `disp_data`.
- `scan_run` out 1: 1 while in AUTO_RUN.

## Operation
- `mode_auto`, `manual_addr` and `step_n` each pass through a 2-FF synchronizer before any use.
- Debounce on synced `step_n`: a counter increments while the synced level differs from the accepted level and clears when they match. When it reaches DB_CYCLES, the new level is accepted. A falling edge of the accepted level produces a one-cycle `press` pulse. Release is debounced the same way, so each physical press gives exactly one pulse.
- FSM states: MANUAL, AUTO_RUN, AUTO_HOLD.
  - MANUAL: `reg_addr` <= synced `manual_addr` every cycle. `press` is ignored. Synced `mode_auto`=1 moves to AUTO_RUN; `reg_addr` holds its current value and the dwell counter clears to 0.
  - AUTO_RUN: the dwell counter increments each cycle. When it equals DWELL-1, it clears and `reg_addr` increments modulo 32 (31 wraps to 0). `press` moves to AUTO_HOLD.
  - AUTO_HOLD: `reg_addr` and the dwell counter are frozen. `press` moves to AUTO_RUN, and the counter resumes from its frozen value.
  - From either auto state, synced `mode_auto`=0 moves to MANUAL. This takes priority over `press` and over a dwell expiry in the same cycle.
- `press` and dwell expiry in the same AUTO_RUN cycle: the address increments, then the FSM enters AUTO_HOLD.
- Display pipeline: every cycle, `disp_data` <= `reg_data` and `disp_addr` <= `reg_addr`, so in-place register changes stay live while holding.
- Address arithmetic is unsigned 5-bit with natural wrap. The dwell counter is DWELL_W bits and never exceeds DWELL-1.

## Timing
- Reset values: `reg_addr`=0, `disp_data`=0, `disp_addr`=0, `scan_run`=0, state MANUAL, all counters 0, accepted button level 1, synchronizer flops 1 for `step_n` and 0 otherwise.
- Switch change to `reg_addr` in MANUAL: 3 cycles (2 sync + 1 register).
- `reg_addr` to `disp_addr`/`disp_data`: 1 cycle.
- `mode_auto` change to state change: 3 cycles.
- `step_n` low to `press`: 2 + DB_CYCLES cycles; the state changes on the following edge.
- A bounce shorter than DB_CYCLES cycles produces no `press`.
- AUTO_RUN address period: exactly DWELL cycles. With DWELL=1 the address changes every cycle.
- Reset asserted mid-scan or mid-debounce returns all outputs to reset values immediately; no pending `press` survives reset.

## Structure
- `nf_reg_scan_pkg`: state enum (MANUAL, AUTO_RUN, AUTO_HOLD) and default DWELL/DB_CYCLES constants.
- Sub-module `nf_debounce`: synchronizer, stable counter and falling-edge `press` output; parameterized by DB_W/DB_CYCLES and reusable for `key[1]`.
- Top of this block: mode synchronizer, FSM, dwell counter, address register and display registers.

## Test plan
Bench parameters: DWELL=4, DB_CYCLES=3.
- Reset, then `mode_auto`=0, `manual_addr`=5'd9 -> `reg_addr`=9 three cycles later; `disp_addr`=9 and `disp_data`=model[9] one cycle after that.
- `mode_auto`=1 with `reg_addr`=30 -> `scan_run`=1; `reg_addr` sequence 30,31,0,1, each value held exactly 4 cycles.
- `step_n` low 2 cycles, then high -> no `press`, scan continues. `step_n` low 10 cycles -> AUTO_HOLD and `reg_addr` frozen. A second press -> AUTO_RUN, and the remaining dwell count completes first.
- `press` lands on the dwell-expiry cycle at address 7 -> `reg_addr`=8, state AUTO_HOLD.
- In AUTO_HOLD, the bench changes model[12] with `reg_addr`=12 -> `disp_data` follows within 1 cycle.
- `resetn` pulsed low mid-AUTO_RUN at address 17 -> all outputs 0 asynchronously. On release with `mode_auto`=1, the scan restarts from 0 after 3 cycles.
